apb2_cmd_master: RTL and testbench

APB2 initiator that turns single-beat command tokens on a valid/ready stream into APB2 transfers and returns each result as a response token. It drives the same APB2 bus the BLDC peripheral responds on. Uses: self-test and bring-up of `apb2_bldc_perpheral` without the EMPU, and the bus-side engine for a future UART-to-APB debug bridge. One transfer is in flight at a time, with a bounded wait-state timeout.

---
 rtl/apb2_cmd_master.sv | 145 ++++++++++++++
 tb/tb_apb2_cmd_master.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/apb2_cmd_master.sv
// apb2_cmd_master: valid/ready command tokens to single APB2 transfers with wait-state timeout
module apb2_cmd_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [2:0] PPROT = 3'b000
) (
  input  logic                pclk,
  input  logic                prst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  output logic [2:0]          pprot,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);
  localparam int SW = DATA_W / 8;
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic cmd_ready_q, cmd_ready_d, psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [SW-1:0] pstrb_q, pstrb_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_timeout_q, rsp_timeout_d;
  logic timeout_hit, done;
  // next state and next registered outputs; bus fields are zeroed whenever psel drops
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cmd_ready_d = 1'b0;
    psel_d = 1'b0;
    penable_d = 1'b0;
    pwrite_d = pwrite_q;
    paddr_d = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d = pstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    timeout_hit = TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST;
    done = pready || timeout_hit;
    case (state_q)
      IDLE: begin
        state_d = cmd_valid ? SETUP : IDLE;
        cmd_ready_d = !cmd_valid;
        psel_d = cmd_valid;
        cnt_d = '0;
        pwrite_d = cmd_valid && cmd_write;
        paddr_d = cmd_valid ? cmd_addr : '0;
        pwdata_d = cmd_valid && cmd_write ? cmd_wdata : '0;
        pstrb_d = cmd_valid && cmd_write ? cmd_strb : '0;
      end
      SETUP: begin
        state_d = ACCESS;
        psel_d = 1'b1;
        penable_d = 1'b1;
      end
      ACCESS: begin
        state_d = done ? RESP : ACCESS;
        psel_d = !done;
        penable_d = !done;
        rsp_valid_d = done;
        rsp_rdata_d = pready && !pwrite_q ? prdata : '0;
        rsp_err_d = pready ? pslverr : timeout_hit;
        rsp_timeout_d = !pready && timeout_hit;
        cnt_d = cnt_q == '1 ? cnt_q : cnt_q + 1'b1;
        pwrite_d = done ? 1'b0 : pwrite_q;
        paddr_d = done ? '0 : paddr_q;
        pwdata_d = done ? '0 : pwdata_q;
        pstrb_d = done ? '0 : pstrb_q;
      end
      RESP: begin
        state_d = rsp_ready ? IDLE : RESP;
        cmd_ready_d = rsp_ready;
        rsp_valid_d = !rsp_ready;
        rsp_rdata_d = rsp_ready ? '0 : rsp_rdata_q;
        rsp_err_d = !rsp_ready && rsp_err_q;
        rsp_timeout_d = !rsp_ready && rsp_timeout_q;
      end
    endcase
  end
  // state and output registers; reset abandons any transfer or pending response
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cmd_ready_q <= 1'b1;
      psel_q <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q <= '0;
      pwdata_q <= '0;
      pstrb_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      pwrite_q <= pwrite_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign psel = psel_q;
  assign penable = penable_q;
  assign pwrite = pwrite_q;
  assign paddr = paddr_q;
  assign pwdata = pwdata_q;
  assign pstrb = pstrb_q;
  assign pprot = PPROT;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb2_cmd_master.sv
// tb_apb2_cmd_master: randomized transfers checked against a per-transaction outcome model
module tb_apb2_cmd_master;
  localparam int TO = 4;
  localparam logic [2:0] PP = 3'b101;
  logic pclk = 1'b0;
  logic prst = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0, prdata = '0;
  logic [3:0] cmd_strb = '0;
  logic pready = 1'b0, pslverr = 1'b0;
  logic cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite;
  logic [31:0] rsp_rdata, pwdata;
  logic [7:0] paddr;
  logic [3:0] pstrb;
  logic [2:0] pprot;
  int checks = 0;
  int errors = 0;
  apb2_cmd_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(TO), .PPROT(PP)) dut (
    .pclk(pclk), .prst(prst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );
  always #5 pclk = ~pclk;
  task automatic step();
    @(posedge pclk);
    #1;
  endtask
  task automatic test_reset();
    prst = 1'b1;
    step();
    step();
    checks++;
    if ({cmd_ready, psel, penable, rsp_valid, paddr, pwdata, pstrb, pwrite, rsp_err, rsp_timeout, rsp_rdata, pprot} !== {1'b1, 3'b0, 8'h0, 32'h0, 4'h0, 3'b0, 32'h0, PP})
      $display("FAIL reset: ready=%0b psel=%0b pen=%0b rv=%0b paddr=%h pprot=%b", cmd_ready, psel, penable, rsp_valid, paddr, pprot);
    if ({cmd_ready, psel, penable, rsp_valid, paddr, pwdata, pstrb, pwrite, rsp_err, rsp_timeout, rsp_rdata, pprot} !== {1'b1, 3'b0, 8'h0, 32'h0, 4'h0, 3'b0, 32'h0, PP}) errors++;
    prst = 1'b0;
  endtask
  task automatic run_txn(input string name, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input int waits, input logic [31:0] rd, input bit serr, input int bp);
    bit to;
    int exp_acc, acc;
    logic [31:0] exp_rd;
    logic [46:0] exp_bus;
    to = waits >= TO;
    exp_acc = to ? TO : waits + 1;
    exp_rd = (!wr && !to) ? rd : 32'h0;
    exp_bus = {2'b10, wr, a, wr ? wd : 32'h0, wr ? st : 4'h0};
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_ready: got %0b want 1", name, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_strb = st;
    pready = 1'b0; rsp_ready = 1'b0;
    step();
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = $urandom; cmd_strb = 4'($urandom);
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, pstrb, cmd_ready, rsp_valid} !== {exp_bus, 2'b00}) begin
      errors++;
      $display("FAIL %s setup: got %h want %h", name, {psel, penable, pwrite, paddr, pwdata, pstrb, cmd_ready, rsp_valid}, {exp_bus, 2'b00});
    end
    step();
    acc = 0;
    while (!rsp_valid && acc < 12) begin
      acc++;
      checks++;
      if ({psel, penable, pwrite, paddr, pwdata, pstrb, cmd_ready} !== {exp_bus | {2'b01, 45'h0}, 1'b0}) begin
        errors++;
        $display("FAIL %s access%0d: got %h want %h", name, acc, {psel, penable, pwrite, paddr, pwdata, pstrb, cmd_ready}, {exp_bus | {2'b01, 45'h0}, 1'b0});
      end
      pready = (acc == waits + 1);
      prdata = pready ? rd : $urandom;
      pslverr = pready ? serr : 1'($urandom);
      step();
    end
    pready = 1'b0; pslverr = 1'b0;
    checks++;
    if (acc != exp_acc) begin
      errors++;
      $display("FAIL %s access_cycles: got %0d want %0d", name, acc, exp_acc);
    end
    for (int b = 0; b <= bp; b++) begin
      checks++;
      if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, psel, penable, pwrite, paddr, pwdata, pstrb} !== {1'b1, exp_rd, serr | to, to, 48'h0}) begin
        errors++;
        $display("FAIL %s resp%0d: got v=%0b rd=%h err=%0b to=%0b rdy=%0b psel=%0b want rd=%h err=%0b to=%0b",
                 name, b, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, psel, exp_rd, serr | to, to);
      end
      rsp_ready = (b == bp);
      cmd_valid = (b != bp);
      step();
    end
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready, rsp_err, rsp_timeout, rsp_rdata, psel} !== {2'b01, 2'b00, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL %s back_to_idle: rv=%0b rdy=%0b err=%0b to=%0b rd=%h psel=%0b", name, rsp_valid, cmd_ready, rsp_err, rsp_timeout, rsp_rdata, psel);
    end
  endtask
  task automatic test_write_zero_wait();
    run_txn("wr0", 1'b1, 8'h0C, 32'h1234_5678, 4'hF, 0, $urandom, 1'b0, 0);
  endtask
  task automatic test_read_waits();
    run_txn("rd3", 1'b0, 8'h04, $urandom, 4'hF, 3, 32'hDEAD_BEEF, 1'b0, 0);
  endtask
  task automatic test_slverr_backpressure();
    run_txn("slverr_bp", 1'b0, 8'h10, $urandom, 4'h3, 1, 32'hCAFE_0001, 1'b1, 5);
  endtask
  task automatic test_timeout();
    run_txn("timeout", 1'b0, 8'h20, $urandom, 4'hF, 50, 32'h5555_AAAA, 1'b0, 1);
    run_txn("timeout_wr", 1'b1, 8'h21, 32'h0BAD_F00D, 4'h5, 50, 32'h5555_AAAA, 1'b0, 0);
    run_txn("ready_on_last", 1'b0, 8'h24, $urandom, 4'hF, TO - 1, 32'h7777_1234, 1'b0, 0);
  endtask
  task automatic test_random();
    for (int i = 0; i < 24; i++)
      run_txn("rand", 1'($urandom), 8'($urandom), $urandom, 4'($urandom), $urandom_range(0, 6), $urandom, 1'($urandom), $urandom_range(0, 3));
  endtask
  task automatic test_reset_mid_access();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h22; cmd_wdata = 32'hA5A5_0000; cmd_strb = 4'hC;
    pready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++;
      $display("FAIL mid_access_pre: psel=%0b penable=%0b want 1 1", psel, penable);
    end
    prst = 1'b1;
    step();
    checks++;
    if ({psel, penable, rsp_valid, cmd_ready, pwrite, paddr, pwdata, pstrb, pprot} !== {4'b0001, 1'b0, 8'h0, 32'h0, 4'h0, PP}) begin
      errors++;
      $display("FAIL mid_access_reset: psel=%0b pen=%0b rv=%0b rdy=%0b paddr=%h", psel, penable, rsp_valid, cmd_ready, paddr);
    end
    step();
    prst = 1'b0;
    pready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if ({rsp_valid, psel, cmd_ready} !== 3'b001) begin
        errors++;
        $display("FAIL post_reset_quiet%0d: rv=%0b psel=%0b rdy=%0b want 0 0 1", c, rsp_valid, psel, cmd_ready);
      end
    end
    pready = 1'b0;
  endtask
  task automatic test_back_to_back();
    logic [7:0] ea [3];
    logic [31:0] ed [3];
    int cyc [$];
    logic [7:0] sa [$];
    logic [31:0] sd [$];
    int idx;
    bit acc;
    for (int i = 0; i < 3; i++) begin
      ea[i] = 8'($urandom);
      ed[i] = $urandom;
    end
    idx = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = ea[0]; cmd_wdata = ed[0]; cmd_strb = 4'hF;
    rsp_ready = 1'b1; pready = 1'b1; pslverr = 1'b0;
    for (int c = 0; c < 18; c++) begin
      acc = cmd_ready && cmd_valid;
      step();
      if (psel && !penable) begin
        cyc.push_back(c);
        sa.push_back(paddr);
        sd.push_back(pwdata);
      end
      if (acc) begin
        idx++;
        cmd_valid = idx < 3;
        cmd_addr = idx < 3 ? ea[idx] : 8'h0;
        cmd_wdata = idx < 3 ? ed[idx] : 32'h0;
      end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0; pready = 1'b0;
    checks++;
    if (cyc.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d transfers want 3", cyc.size());
    end
    for (int i = 0; i < cyc.size() && i < 3; i++) begin
      checks++;
      if ({sa[i], sd[i]} !== {ea[i], ed[i]}) begin
        errors++;
        $display("FAIL b2b_order%0d: got %h/%h want %h/%h", i, sa[i], sd[i], ea[i], ed[i]);
      end
      if (i > 0) begin
        checks++;
        if (cyc[i] - cyc[i-1] != 4) begin
          errors++;
          $display("FAIL b2b_period%0d: got %0d want 4", i, cyc[i] - cyc[i-1]);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_slverr_backpressure();
    test_timeout();
    test_random();
    test_reset_mid_access();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
